seven_seg_scanner: RTL and testbench

Parametrised multiplexed seven-segment display driver. It time-division-scans `N_DIGITS` common-anode/cathode digits from a packed hex value bus, with programmable per-digit slot time and anti-ghosting blank interval. It adds PWM brightness, leading-zero blanking, a per-digit force-blank mask and frame-coherent input snapshots. It sits between the cronometer counter/formatting logic and the board display pins.

---
 rtl/seven_seg_scanner_if.sv | 15 +
 rtl/seven_seg_scanner.sv | 96 +++++++++
 tb/tb_seven_seg_scanner.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/seven_seg_scanner_if.sv
// seven_seg_scanner_if: display data in, segment/digit drive out
//   master drives value/dot/blank_mask/lzb_en/bright and observes seg/dsp/frame_start
//   slave is the scanner side
interface seven_seg_scanner_if #(parameter int N_DIGITS = 8);
  logic [N_DIGITS-1:0][3:0] value;
  logic [N_DIGITS-1:0] dot;
  logic [N_DIGITS-1:0] blank_mask;
  logic lzb_en;
  logic [4:0] bright;
  logic [7:0] seg;
  logic [N_DIGITS-1:0] dsp;
  logic frame_start;
  modport master(output value, dot, blank_mask, lzb_en, bright, input seg, dsp, frame_start);
  modport slave(input value, dot, blank_mask, lzb_en, bright, output seg, dsp, frame_start);
endinterface

// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: multiplexed seven-segment driver with blanking, PWM, LZB and frame snapshots
//   clk, rst_n (sync, active-low)
//   bus.value/dot/blank_mask/lzb_en/bright in; bus.seg {dp,g..a}, bus.dsp one-hot, bus.frame_start out
module seven_seg_scanner #(
  parameter int N_DIGITS = 8,
  parameter int SLOT_CYCLES = 131072,
  parameter int BLANK_CYCLES = 256,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit DSP_ACTIVE_LOW = 1'b1
) (
  input logic clk,
  input logic rst_n,
  seven_seg_scanner_if.slave bus
);
  localparam int CW = $clog2(SLOT_CYCLES);
  localparam int IW = N_DIGITS > 1 ? $clog2(N_DIGITS) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(SLOT_CYCLES - 1);
  localparam logic [CW-1:0] ON_CNT = CW'(BLANK_CYCLES);
  localparam logic [IW-1:0] LAST_IDX = IW'(N_DIGITS - 1);
  localparam logic [N_DIGITS-1:0] ONE = 1;
  localparam logic [6:0] FONT [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                       7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  typedef enum logic {BLANK, ON} phase_t;
  phase_t r_phase;
  logic [CW-1:0] r_cnt;
  logic [IW-1:0] r_idx;
  logic [3:0] r_pwm;
  logic [N_DIGITS-1:0][3:0] r_value;
  logic [N_DIGITS-1:0] r_dot, r_mask;
  logic r_lzb_en;
  logic [4:0] r_bright;
  logic [7:0] r_seg;
  logic [N_DIGITS-1:0] r_dsp;
  logic r_frame_start;
  logic w_snap, w_lzb_en, w_lz, w_lit;
  logic [N_DIGITS-1:0][3:0] w_value;
  logic [N_DIGITS-1:0] w_dot, w_mask;
  logic [4:0] w_bright;
  logic [3:0] w_pwm;
  logic [7:0] w_pat;
  logic [CW-1:0] w_cnt_nxt;
  logic [IW-1:0] w_idx_nxt;
  // the snapshot cycle already displays the freshly captured inputs
  assign w_snap = r_cnt == '0 && r_idx == '0;
  assign w_value = w_snap ? bus.value : r_value;
  assign w_dot = w_snap ? bus.dot : r_dot;
  assign w_mask = w_snap ? bus.blank_mask : r_mask;
  assign w_lzb_en = w_snap ? bus.lzb_en : r_lzb_en;
  assign w_bright = w_snap ? bus.bright : r_bright;
  assign w_cnt_nxt = r_cnt == LAST_CNT ? '0 : r_cnt + 1'b1;
  assign w_idx_nxt = r_cnt != LAST_CNT ? r_idx : r_idx == LAST_IDX ? '0 : r_idx + 1'b1;
  // PWM phase restarts on the first ON cycle of every slot; bright >= 16 is always lit
  assign w_pwm = r_cnt == ON_CNT ? 4'd0 : r_pwm;
  assign w_lit = r_phase == ON && {1'b0, w_pwm} < w_bright;
  // current digit is a leading zero if it and every more significant digit are zero
  always_comb begin
    w_lz = w_lzb_en && r_idx != '0;
    for (int j = 0; j < N_DIGITS; j++)
      if (j >= int'(r_idx) && w_value[j] != 4'h0) w_lz = 1'b0;
  end
  assign w_pat = {w_dot[r_idx], (w_mask[r_idx] || w_lz) ? 7'h00 : FONT[w_value[r_idx]]};
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_idx <= '0;
      r_pwm <= '0;
      r_phase <= BLANK_CYCLES > 0 ? BLANK : ON;
      r_value <= '0;
      r_dot <= '0;
      r_mask <= '0;
      r_lzb_en <= 1'b0;
      r_bright <= '0;
      r_seg <= {8{SEG_ACTIVE_LOW}};
      r_dsp <= {N_DIGITS{DSP_ACTIVE_LOW}};
      r_frame_start <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_idx <= w_idx_nxt;
      r_pwm <= w_pwm + 4'(r_phase == ON);
      r_phase <= w_cnt_nxt < ON_CNT ? BLANK : ON;
      if (w_snap) begin
        r_value <= bus.value;
        r_dot <= bus.dot;
        r_mask <= bus.blank_mask;
        r_lzb_en <= bus.lzb_en;
        r_bright <= bus.bright;
      end
      r_seg <= {8{SEG_ACTIVE_LOW}} ^ (w_lit ? w_pat : 8'h00);
      r_dsp <= {N_DIGITS{DSP_ACTIVE_LOW}} ^ (w_lit ? ONE << r_idx : '0);
      r_frame_start <= w_snap;
    end
  end
  assign bus.seg = r_seg;
  assign bus.dsp = r_dsp;
  assign bus.frame_start = r_frame_start;
endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb_seven_seg_scanner: randomized and directed checks of the scanner against a frame-position model
module tb_seven_seg_scanner;
  localparam int ND = 4, SLOT = 40, BLK = 8, FRAME = ND * SLOT;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int errors = 0, checks = 0;
  seven_seg_scanner_if #(.N_DIGITS(ND)) bus ();
  seven_seg_scanner #(.N_DIGITS(ND), .SLOT_CYCLES(SLOT), .BLANK_CYCLES(BLK),
                      .SEG_ACTIVE_LOW(1'b1), .DSP_ACTIVE_LOW(1'b1))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  logic [6:0] font [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask
  task automatic step(int n);
    repeat (n) @(posedge clk);
    #2;
  endtask
  // model: output after an edge is a function of the cycle's position in the frame and the
  // inputs captured at the start of that frame
  logic [ND-1:0][3:0] s_val;
  logic [ND-1:0] s_dot, s_mask;
  logic s_lzb;
  int s_bright;
  logic [7:0] e_seg;
  logic [3:0] e_dsp;
  logic e_fs;
  bit m_valid = 0;
  int m_t = 0;
  initial forever begin
    @(negedge clk);
    if (m_valid) begin
      check("model_seg", bus.seg, e_seg);
      check("model_dsp", bus.dsp, e_dsp);
      check("model_frame_start", bus.frame_start, e_fs);
    end
    if (!rst_n) begin
      e_seg = 8'hFF;
      e_dsp = 4'hF;
      e_fs = 1'b0;
      m_t = 0;
    end else begin
      int p, idx, c, hi;
      logic lit, blank;
      p = m_t % FRAME;
      idx = p / SLOT;
      c = p % SLOT;
      if (p == 0) begin
        s_val = bus.value;
        s_dot = bus.dot;
        s_mask = bus.blank_mask;
        s_lzb = bus.lzb_en;
        s_bright = int'(bus.bright);
      end
      hi = -1;
      for (int j = 0; j < ND; j++) if (s_val[j] != 4'h0) hi = j;
      blank = s_mask[idx] || (s_lzb && idx > 0 && idx > hi);
      lit = c >= BLK && ((c - BLK) % 16) < s_bright;
      e_fs = p == 0;
      e_seg = lit ? ~{s_dot[idx], blank ? 7'h00 : font[s_val[idx]]} : 8'hFF;
      e_dsp = lit ? ~(4'b0001 << idx) : 4'hF;
      m_t++;
    end
    m_valid = 1;
  end
  initial begin
    int n;
    bus.value = 16'h3210;
    bus.dot = 4'h0;
    bus.blank_mask = 4'h0;
    bus.lzb_en = 1'b0;
    bus.bright = 5'd16;
    step(2);
    check("reset_seg", bus.seg, 8'hFF);
    check("reset_dsp", bus.dsp, 4'hF);
    step(1);
    rst_n = 1'b1;
    step(1);
    check("first_frame_start", bus.frame_start, 1'b1);
    check("first_blank_dsp", bus.dsp, 4'hF);
    step(8);
    check("scan_d0_dsp", bus.dsp, 4'b1110);
    check("scan_d0_seg", bus.seg, 8'hC0);
    step(31);
    check("scan_d0_last_dsp", bus.dsp, 4'b1110);
    step(1);
    check("scan_d1_blank_dsp", bus.dsp, 4'hF);
    step(8);
    check("scan_d1_dsp", bus.dsp, 4'b1101);
    check("scan_d1_seg", bus.seg, 8'hF9);
    step(40);
    check("scan_d2_dsp", bus.dsp, 4'b1011);
    check("scan_d2_seg", bus.seg, 8'hA4);
    step(40);
    check("scan_d3_dsp", bus.dsp, 4'b0111);
    check("scan_d3_seg", bus.seg, 8'hB0);
    step(32);
    check("frame_period", bus.frame_start, 1'b1);
    step(40);
    bus.value = 16'h9999;
    step(8);
    check("coh_d1_seg", bus.seg, 8'hF9);
    step(40);
    check("coh_d2_seg", bus.seg, 8'hA4);
    step(40);
    check("coh_d3_seg", bus.seg, 8'hB0);
    step(32);
    check("coh_frame_start", bus.frame_start, 1'b1);
    step(8);
    check("coh_new_seg", bus.seg, 8'h90);
    bus.value = 16'h0070;
    bus.lzb_en = 1'b1;
    bus.dot = 4'b0100;
    step(160);
    check("lzb_d0_seg", bus.seg, 8'hC0);
    step(40);
    check("lzb_d1_seg", bus.seg, 8'hF8);
    step(40);
    check("lzb_d2_seg", bus.seg, 8'h7F);
    step(40);
    check("lzb_d3_seg", bus.seg, 8'hFF);
    check("lzb_d3_dsp", bus.dsp, 4'b0111);
    bus.value = 16'h0000;
    bus.dot = 4'h0;
    step(40);
    check("lzb_zero_d0_seg", bus.seg, 8'hC0);
    step(40);
    check("lzb_zero_d1_seg", bus.seg, 8'hFF);
    bus.value = 16'h3210;
    bus.lzb_en = 1'b0;
    bus.bright = 5'd4;
    step(112);
    bus.bright = 5'd0;
    n = 0;
    for (int i = 1; i <= FRAME; i++) begin
      step(1);
      if (bus.dsp != 4'hF) n++;
      if (i == 8 || i == 11 || i == 24) check("pwm4_on", bus.dsp, 4'b1110);
      if (i == 12 || i == 23) check("pwm4_off", bus.dsp, 4'hF);
    end
    check("pwm4_lit_count", n, 32);
    bus.bright = 5'd31;
    n = 0;
    for (int i = 1; i <= FRAME; i++) begin
      step(1);
      if (bus.dsp != 4'hF) n++;
    end
    check("pwm0_lit_count", n, 0);
    bus.bright = 5'd16;
    n = 0;
    for (int i = 1; i <= FRAME; i++) begin
      step(1);
      if (bus.dsp != 4'hF) n++;
    end
    check("pwm31_lit_count", n, 128);
    repeat (640) begin
      step(1);
      if ($urandom_range(0, 15) == 0) bus.value = 16'($urandom) >> $urandom_range(0, 16);
      if ($urandom_range(0, 31) == 0) bus.dot = 4'($urandom);
      if ($urandom_range(0, 31) == 0) bus.blank_mask = 4'($urandom);
      if ($urandom_range(0, 31) == 0) bus.lzb_en = 1'($urandom);
      if ($urandom_range(0, 31) == 0) bus.bright = 5'($urandom_range(0, 31));
    end
    rst_n = 1'b0;
    step(2);
    check("rst2_seg", bus.seg, 8'hFF);
    check("rst2_dsp", bus.dsp, 4'hF);
    bus.value = 16'h3210;
    bus.dot = 4'h0;
    bus.blank_mask = 4'h0;
    bus.lzb_en = 1'b0;
    bus.bright = 5'd16;
    rst_n = 1'b1;
    step(1);
    check("rst2_frame_start", bus.frame_start, 1'b1);
    step(88);
    check("mid_d2_dsp", bus.dsp, 4'b1011);
    step(2);
    rst_n = 1'b0;
    step(1);
    check("mid_rst_seg", bus.seg, 8'hFF);
    check("mid_rst_dsp", bus.dsp, 4'hF);
    check("mid_rst_fs", bus.frame_start, 1'b0);
    bus.value = 16'h5555;
    rst_n = 1'b1;
    step(1);
    check("restart_frame_start", bus.frame_start, 1'b1);
    step(8);
    check("restart_d0_dsp", bus.dsp, 4'b1110);
    check("restart_d0_seg", bus.seg, 8'h92);
    step(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
